// File: rtl/axi_lite_pkg.sv
// Shared AXI4-lite definitions: response codes and channel FSM state encodings.
package axi_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE   = 2'd0,
        W_HAVE_A = 2'd1,
        W_HAVE_D = 2'd2,
        W_RESP   = 2'd3
    } w_state_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } r_state_t;

endpackage

// File: rtl/axi_mem_array.sv
// Synchronous 1W1R word RAM with per-byte write enables and a registered read port.
// Storage is never reset; a same-edge read of the written word returns the old contents.
module axi_mem_array #(
    parameter int WORDS = 256,
    parameter int AW    = $clog2(WORDS)
) (
    input  logic          CLK,
    input  logic [3:0]    wr_be,
    input  logic [AW-1:0] wr_idx,
    input  logic [31:0]   wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_idx,
    output logic [31:0]   rd_data
);

    logic [31:0] mem [WORDS];

    always_ff @(posedge CLK) begin
        for (int k = 0; k < 4; k++) begin
            if (wr_be[k]) begin
                mem[wr_idx][8*k +: 8] <= wr_data[8*k +: 8];
            end
        end
        if (rd_en) begin
            rd_data <= mem[rd_idx];
        end
    end

endmodule

// File: rtl/axi_lite_mem_slave.sv
// AXI4-lite word memory slave: independent write/read FSMs over one 1W1R array.
// Build option AXI_MEM_WSTRB_EN: honour wstrb byte lanes; otherwise every write stores the full word.
module axi_lite_mem_slave
    import axi_lite_pkg::*;
#(
    parameter int                sword     = 32,
    parameter int                MEM_WORDS = 256,
    parameter logic [sword-1:0]  BASE_ADDR = 32'h0000_0000
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             axi_awvalid,
    output logic             axi_awready,
    input  logic [sword-1:0] axi_awaddr,
    input  logic [2:0]       axi_awprot,
    input  logic             axi_wvalid,
    output logic             axi_wready,
    input  logic [sword-1:0] axi_wdata,
    input  logic [3:0]       axi_wstrb,
    output logic             axi_bvalid,
    input  logic             axi_bready,
    output logic [1:0]       axi_bresp,
    input  logic             axi_arvalid,
    output logic             axi_arready,
    input  logic [sword-1:0] axi_araddr,
    input  logic [2:0]       axi_arprot,
    output logic             axi_rvalid,
    input  logic             axi_rready,
    output logic [sword-1:0] axi_rdata,
    output logic [1:0]       axi_rresp
);

    localparam int               AW   = $clog2(MEM_WORDS);
    localparam logic [sword-1:0] SPAN = sword'(MEM_WORDS * 4);

    w_state_t w_state, w_next;
    r_state_t r_state, r_next;

    logic [sword-1:0] aw_addr_q, w_data_q;
    logic [3:0]       w_strb_q;
    logic [1:0]       bresp_q, rresp_q;
    logic             aw_hs, w_hs, ar_hs, w_commit;
    logic [sword-1:0] wr_addr_sel, wr_data_sel, wr_off, rd_off;
    logic [3:0]       wr_strb_sel, wr_be;
    logic             wr_ok, rd_ok;
    logic [31:0]      arr_rdata;
    logic             unused_sig;

    assign unused_sig = ^{axi_awprot, axi_arprot};

    assign axi_awready = !RST && (w_state == W_IDLE || w_state == W_HAVE_D);
    assign axi_wready  = !RST && (w_state == W_IDLE || w_state == W_HAVE_A);
    assign axi_bvalid  = !RST && (w_state == W_RESP);
    assign axi_bresp   = bresp_q;
    assign axi_arready = !RST && (r_state == R_IDLE);
    assign axi_rvalid  = !RST && (r_state == R_DATA);
    assign axi_rresp   = rresp_q;
    assign axi_rdata   = (axi_rvalid && rresp_q == RESP_OKAY) ? arr_rdata : '0;

    assign aw_hs = axi_awvalid && axi_awready;
    assign w_hs  = axi_wvalid && axi_wready;
    assign ar_hs = axi_arvalid && axi_arready;

    always_comb begin
        w_next = w_state;
        case (w_state)
            W_IDLE: begin
                if (aw_hs && w_hs) w_next = W_RESP;
                else if (aw_hs)    w_next = W_HAVE_A;
                else if (w_hs)     w_next = W_HAVE_D;
            end
            W_HAVE_A: if (w_hs)       w_next = W_RESP;
            W_HAVE_D: if (aw_hs)      w_next = W_RESP;
            W_RESP:   if (axi_bready) w_next = W_IDLE;
            default:                  w_next = W_IDLE;
        endcase
    end

    // The array write fires on the edge that enters W_RESP, mixing latched and live channel values.
    assign w_commit    = !RST && (w_next == W_RESP) && (w_state != W_RESP);
    assign wr_addr_sel = (w_state == W_HAVE_A) ? aw_addr_q : axi_awaddr;
    assign wr_data_sel = (w_state == W_HAVE_D) ? w_data_q  : axi_wdata;
    assign wr_off      = wr_addr_sel - BASE_ADDR;
    assign wr_ok       = wr_off < SPAN;
`ifdef AXI_MEM_WSTRB_EN
    assign wr_strb_sel = (w_state == W_HAVE_D) ? w_strb_q : axi_wstrb;
`else
    assign wr_strb_sel = 4'hF;
`endif
    assign wr_be = (w_commit && wr_ok) ? wr_strb_sel : 4'b0000;

    always_comb begin
        r_next = r_state;
        case (r_state)
            R_IDLE:  if (ar_hs)      r_next = R_DATA;
            R_DATA:  if (axi_rready) r_next = R_IDLE;
            default:                 r_next = R_IDLE;
        endcase
    end

    assign rd_off = axi_araddr - BASE_ADDR;
    assign rd_ok  = rd_off < SPAN;

    always_ff @(posedge CLK) begin
        if (RST) begin
            w_state <= W_IDLE;
            r_state <= R_IDLE;
            bresp_q <= RESP_OKAY;
            rresp_q <= RESP_OKAY;
        end else begin
            w_state <= w_next;
            r_state <= r_next;
            if (w_commit) bresp_q <= wr_ok ? RESP_OKAY : RESP_SLVERR;
            if (ar_hs)    rresp_q <= rd_ok ? RESP_OKAY : RESP_SLVERR;
        end
    end

    always_ff @(posedge CLK) begin
        if (aw_hs) aw_addr_q <= axi_awaddr;
        if (w_hs) begin
            w_data_q <= axi_wdata;
            w_strb_q <= axi_wstrb;
        end
    end

    axi_mem_array #(
        .WORDS (MEM_WORDS),
        .AW    (AW)
    ) u_array (
        .CLK     (CLK),
        .wr_be   (wr_be),
        .wr_idx  (wr_off[AW+1:2]),
        .wr_data (wr_data_sel),
        .rd_en   (ar_hs && rd_ok),
        .rd_idx  (rd_off[AW+1:2]),
        .rd_data (arr_rdata)
    );

endmodule

// File: tb/tb_axi_lite_mem_slave.sv
// Randomized bench for axi_lite_mem_slave against a word-array reference model.
module tb_axi_lite_mem_slave;

    localparam logic [31:0] BASE  = 32'h0000_0000;
    localparam int          WORDS = 256;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        axi_awvalid = 1'b0, axi_awready;
    logic [31:0] axi_awaddr = '0;
    logic [2:0]  axi_awprot = '0;
    logic        axi_wvalid = 1'b0, axi_wready;
    logic [31:0] axi_wdata = '0;
    logic [3:0]  axi_wstrb = '0;
    logic        axi_bvalid, axi_bready = 1'b0;
    logic [1:0]  axi_bresp;
    logic        axi_arvalid = 1'b0, axi_arready;
    logic [31:0] axi_araddr = '0;
    logic [2:0]  axi_arprot = '0;
    logic        axi_rvalid, axi_rready = 1'b0;
    logic [31:0] axi_rdata;
    logic [1:0]  axi_rresp;

    int checks = 0;
    int errors = 0;
    logic [31:0] ref_mem [WORDS];

    axi_lite_mem_slave #(.sword(32), .MEM_WORDS(WORDS), .BASE_ADDR(BASE)) dut (
        .CLK(CLK), .RST(RST),
        .axi_awvalid(axi_awvalid), .axi_awready(axi_awready), .axi_awaddr(axi_awaddr), .axi_awprot(axi_awprot),
        .axi_wvalid(axi_wvalid), .axi_wready(axi_wready), .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb),
        .axi_bvalid(axi_bvalid), .axi_bready(axi_bready), .axi_bresp(axi_bresp),
        .axi_arvalid(axi_arvalid), .axi_arready(axi_arready), .axi_araddr(axi_araddr), .axi_arprot(axi_arprot),
        .axi_rvalid(axi_rvalid), .axi_rready(axi_rready), .axi_rdata(axi_rdata), .axi_rresp(axi_rresp)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit in_rng(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return off < WORDS * 4;
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'((a - BASE) / 4);
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        return in_rng(a) ? ref_mem[widx(a)] : 32'h0;
    endfunction

    function automatic logic [1:0] model_resp(input logic [31:0] a);
        return in_rng(a) ? 2'b00 : 2'b10;
    endfunction

    task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        if (in_rng(a)) begin
            for (int k = 0; k < 4; k++) begin
`ifdef AXI_MEM_WSTRB_EN
                if (s[k]) ref_mem[widx(a)][8*k +: 8] = d[8*k +: 8];
`else
                ref_mem[widx(a)][8*k +: 8] = d[8*k +: 8];
`endif
            end
        end
    endtask

    // Caller is at a negedge; returns at a negedge with the write channel idle.
    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int d_aw, input int d_w, input int bdly, input bit keep_aw,
                            output logic [1:0] resp);
        int n;
        logic [1:0] first;
        fork
            begin
                int na;
                for (int i = 0; i < d_aw; i++) begin
                    if (i > d_w) begin
                        chk("have_d_awready", axi_awready, 1);
                        chk("have_d_wready", axi_wready, 0);
                    end
                    @(negedge CLK);
                end
                axi_awvalid = 1'b1;
                axi_awaddr  = addr;
                na = 0;
                while (!axi_awready && na < 40) begin @(negedge CLK); na++; end
                if (na >= 40) chk("aw_timeout", 0, 1);
                @(negedge CLK);
                if (!keep_aw) axi_awvalid = 1'b0;
            end
            begin
                int nw;
                for (int i = 0; i < d_w; i++) begin
                    if (i > d_aw) begin
                        chk("have_a_awready", axi_awready, 0);
                        chk("have_a_wready", axi_wready, 1);
                    end
                    @(negedge CLK);
                end
                axi_wvalid = 1'b1;
                axi_wdata  = data;
                axi_wstrb  = strb;
                nw = 0;
                while (!axi_wready && nw < 40) begin @(negedge CLK); nw++; end
                if (nw >= 40) chk("w_timeout", 0, 1);
                @(negedge CLK);
                axi_wvalid = 1'b0;
            end
        join
        n = 0;
        while (!axi_bvalid && n < 40) begin @(negedge CLK); n++; end
        if (n >= 40) chk("b_timeout", 0, 1);
        first = axi_bresp;
        for (int i = 0; i < bdly; i++) begin
            chk("bvalid_hold", axi_bvalid, 1);
            chk("bresp_hold", axi_bresp, first);
            chk("resp_awready", axi_awready, 0);
            chk("resp_wready", axi_wready, 0);
            @(negedge CLK);
        end
        resp = axi_bresp;
        axi_bready = 1'b1;
        @(negedge CLK);
        axi_bready  = 1'b0;
        axi_awvalid = 1'b0;
        chk("bvalid_drop", axi_bvalid, 0);
    endtask

    task automatic do_read(input logic [31:0] addr, input int rdly,
                           output logic [31:0] data, output logic [1:0] resp);
        int n;
        axi_arvalid = 1'b1;
        axi_araddr  = addr;
        n = 0;
        while (!axi_arready && n < 40) begin @(negedge CLK); n++; end
        if (n >= 40) chk("ar_timeout", 0, 1);
        chk("rvalid_pre", axi_rvalid, 0);
        @(negedge CLK);
        axi_arvalid = 1'b0;
        chk("rvalid_lat", axi_rvalid, 1);
        data = axi_rdata;
        resp = axi_rresp;
        for (int i = 0; i < rdly; i++) begin
            @(negedge CLK);
            chk("rvalid_hold", axi_rvalid, 1);
            chk("rdata_hold", axi_rdata, data);
        end
        axi_rready = 1'b1;
        @(negedge CLK);
        axi_rready = 1'b0;
        chk("rvalid_drop", axi_rvalid, 0);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                      input int d_aw, input int d_w, input int bdly, input bit keep_aw);
        logic [1:0] resp;
        do_write(a, d, s, d_aw, d_w, bdly, keep_aw, resp);
        chk("bresp", resp, model_resp(a));
        model_write(a, d, s);
    endtask

    task automatic rd(input logic [31:0] a, input int rdly);
        logic [31:0] data;
        logic [1:0]  resp;
        do_read(a, rdly, data, resp);
        chk("rdata", data, model_read(a));
        chk("rresp", resp, model_resp(a));
    endtask

    // Write and read handshake on the same edge; the read must see the pre-write word.
    task automatic wr_rd_same_edge(input logic [31:0] wa, input logic [31:0] wd, input logic [3:0] ws,
                                   input logic [31:0] ra, input int bdly, input int rdly);
        logic [31:0] exp_rd, got_rd;
        logic [1:0]  bresp, rresp;
        exp_rd = model_read(ra);
        fork
            do_write(wa, wd, ws, 0, 0, bdly, 1'b0, bresp);
            do_read(ra, rdly, got_rd, rresp);
        join
        chk("same_edge_rdata", got_rd, exp_rd);
        chk("same_edge_rresp", rresp, model_resp(ra));
        chk("same_edge_bresp", bresp, model_resp(wa));
        model_write(wa, wd, ws);
    endtask

    function automatic logic [31:0] rand_addr();
        if ($urandom_range(0, 4) == 0) return $urandom();
        return BASE + $urandom_range(0, WORDS * 4 - 1);
    endfunction

    initial begin
        repeat (3) @(negedge CLK);
        chk("rst_awready", axi_awready, 0);
        chk("rst_wready", axi_wready, 0);
        chk("rst_arready", axi_arready, 0);
        chk("rst_bvalid", axi_bvalid, 0);
        chk("rst_rvalid", axi_rvalid, 0);
        RST = 1'b0;
        #1;
        chk("post_rst_awready", axi_awready, 1);
        chk("post_rst_wready", axi_wready, 1);
        chk("post_rst_arready", axi_arready, 1);
        chk("post_rst_bresp", axi_bresp, 0);
        chk("post_rst_rresp", axi_rresp, 0);
        chk("post_rst_rdata", axi_rdata, 0);
        @(negedge CLK);

        for (int i = 0; i < WORDS; i++) wr(BASE + 4 * i, $urandom(), 4'hF, 0, 0, 0, 1'b0);

        wr(BASE + 32'h100, 32'hDEAD_BEEF, 4'hF, 0, 1, 0, 1'b0);
        rd(BASE + 32'h100, 0);
        wr(BASE + 32'h004, 32'h1234_5678, 4'hF, 3, 0, 0, 1'b0);
        rd(BASE + 32'h004, 1);
        wr(BASE + WORDS * 4, 32'hCAFE_F00D, 4'hF, 0, 0, 0, 1'b0);
        rd(BASE + WORDS * 4, 0);
        rd(BASE, 0);
        wr(BASE + 32'h020, 32'h0BAD_F00D, 4'hF, 0, 0, 5, 1'b1);
        rd(BASE + 32'h020, 0);
        wr(BASE + 32'h008, 32'h5555_5555, 4'hF, 0, 0, 0, 1'b0);
        wr_rd_same_edge(BASE + 32'h008, 32'hAAAA_AAAA, 4'hF, BASE + 32'h008, 0, 0);
        rd(BASE + 32'h008, 0);

        axi_awvalid = 1'b1;
        axi_awaddr  = BASE + 32'h040;
        #1;
        chk("pre_rst_awready", axi_awready, 1);
        @(negedge CLK);
        axi_awvalid = 1'b0;
        #1;
        chk("have_a_state", {axi_awready, axi_wready}, 2'b01);
        RST = 1'b1;
        #1;
        chk("mid_rst_ready", {axi_awready, axi_wready, axi_arready}, 3'b000);
        chk("mid_rst_valid", {axi_bvalid, axi_rvalid}, 2'b00);
        @(negedge CLK);
        RST = 1'b0;
        #1;
        chk("rst_idle_ready", {axi_awready, axi_wready, axi_arready}, 3'b111);
        @(negedge CLK);
        rd(BASE + 32'h040, 0);

        wr(BASE, 32'h0, 4'hF, 0, 0, 0, 1'b0);
        wr(BASE, 32'hFFFF_FFFF, 4'b0011, 1, 0, 0, 1'b0);
        rd(BASE, 0);
`ifdef AXI_MEM_WSTRB_EN
        chk("wstrb_lanes", ref_mem[0], 32'h0000_FFFF);
        wr(BASE, 32'h1234_5678, 4'b0000, 0, 0, 0, 1'b0);
        rd(BASE, 0);
`endif

        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 3))
                0, 1: wr(rand_addr(), $urandom(), 4'($urandom_range(0, 15)),
                         $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                         1'($urandom_range(0, 1)));
                2: rd(rand_addr(), $urandom_range(0, 3));
                default: wr_rd_same_edge(rand_addr(), $urandom(), 4'($urandom_range(0, 15)),
                                         rand_addr(), $urandom_range(0, 3), $urandom_range(0, 3));
            endcase
        end

        for (int i = 0; i < WORDS; i++) rd(BASE + 4 * i, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        errors++;
        $display("FAIL watchdog got=timeout exp=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
